rf_wb_scheduler: RTL and testbench

- Owns the single register-file write port and shares it between the in-order pipeline WB stage and the multi-cycle mul/div (M) unit.
- Buffers M results in a small FIFO when the port is busy, and keeps a 32-entry busy scoreboard of registers awaiting M results.
- Raises a stall to ID on RAW/WAW hazards against pending M results, and on write-port starvation.
- Sits between the WB stage / M unit and the register file write inputs (we, waddr, wd).

---
 rtl/rf_wb_scheduler.sv | 178 +++++++++++++++++
 tb/tb_rf_wb_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_scheduler.sv
// rf_wb_scheduler
//
// Arbitrates the single register-file write port between the in-order
// pipeline WB stage and the multi-cycle mul/div (M) unit. The pipeline always
// has priority. M results that cannot reach the port right away are held in a
// small in-order FIFO. A 32-entry busy scoreboard tracks registers that are
// still waiting on an M result. ID is stalled on RAW/WAW hazards against those
// registers, and also when the FIFO has been starved of the port for too long.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   pipe_we/pipe_waddr/pipe_wd      WB stage write request
//   md_issue/md_issue_rd            M op issued from ID (sets a busy bit)
//   md_valid/md_rd/md_result        M result handshake input
//   md_ready                        scheduler accepts the M result this cycle
//   id_rs1/id_rs2/id_rd             ID operand/destination registers
//   id_stall                        stall request to ID/IF
//   rf_we/rf_waddr/rf_wd            register file write port
//   fifo_cnt                        current FIFO occupancy

module rf_wb_scheduler #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pipe_we,
    input  logic [4:0]                    pipe_waddr,
    input  logic [31:0]                   pipe_wd,
    input  logic                          md_issue,
    input  logic [4:0]                    md_issue_rd,
    input  logic                          md_valid,
    input  logic [4:0]                    md_rd,
    input  logic [31:0]                   md_result,
    output logic                          md_ready,
    input  logic [4:0]                    id_rs1,
    input  logic [4:0]                    id_rs2,
    input  logic [4:0]                    id_rd,
    output logic                          id_stall,
    output logic                          rf_we,
    output logic [4:0]                    rf_waddr,
    output logic [31:0]                   rf_wd,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [4:0]    rd_mem_q   [FIFO_DEPTH];
    logic [31:0]   data_mem_q [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   busy_q, busy_d;
    logic [SW-1:0] starve_q, starve_d;

    logic        pipe_win;
    logic        fifo_empty;
    logic        fifo_full;
    logic        pop;
    logic        bypass;
    logic        push;
    logic [4:0]  head_rd;
    logic [31:0] head_wd;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;

    // Port arbitration. The FIFO head is served before any new M result so
    // that M writes always reach the register file in acceptance order; a
    // result may only bypass the FIFO when it is empty. Results for x0 are
    // swallowed: accepted, never written, never queued.
    always_comb begin
        pipe_win   = pipe_we && (pipe_waddr != 5'd0);
        fifo_empty = (cnt_q == '0);
        fifo_full  = (cnt_q == DEPTH_C);
        head_rd    = rd_mem_q[rd_ptr_q];
        head_wd    = data_mem_q[rd_ptr_q];

        md_ready   = !rst && !fifo_full;
        pop        = !rst && !pipe_win && !fifo_empty;
        bypass     = !rst && !pipe_win && fifo_empty && md_valid && (md_rd != 5'd0);
        push       = md_valid && md_ready && (md_rd != 5'd0) && !bypass;

        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wd    = 32'd0;
        if (!rst) begin
            if (pipe_win) begin
                rf_we    = 1'b1;
                rf_waddr = pipe_waddr;
                rf_wd    = pipe_wd;
            end else if (pop) begin
                rf_we    = 1'b1;
                rf_waddr = head_rd;
                rf_wd    = head_wd;
            end else if (bypass) begin
                rf_we    = 1'b1;
                rf_waddr = md_rd;
                rf_wd    = md_result;
            end
        end

        id_stall = !rst && (busy_q[id_rs1] || busy_q[id_rs2] || busy_q[id_rd] ||
                            (starve_q == STARVE_MAX));
    end

    // Next-state for FIFO pointers/occupancy, scoreboard and starve counter.
    // On the scoreboard a same-cycle set wins over a clear, and x0 is never
    // marked busy. The starve counter only runs while a queued result is
    // being blocked by the pipeline; any pop or an empty FIFO clears it.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        clr_mask = 32'd0;
        set_mask = 32'd0;
        if (pop) begin
            clr_mask[head_rd] = 1'b1;
        end else if (bypass) begin
            clr_mask[md_rd] = 1'b1;
        end
        if (md_issue && (md_issue_rd != 5'd0) && !id_stall) begin
            set_mask[md_issue_rd] = 1'b1;
        end
        busy_d    = (busy_q & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;

        if (!fifo_empty && pipe_win) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + SW'(1);
        end else begin
            starve_d = '0;
        end
    end

    // Control state with synchronous reset; a reset discards queued results
    // and all pending busy bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            busy_q   <= '0;
            starve_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            starve_q <= starve_d;
        end
    end

    // FIFO storage needs no reset; only occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem_q[wr_ptr_q]   <= md_rd;
            data_mem_q[wr_ptr_q] <= md_result;
        end
    end

    assign fifo_cnt = cnt_q;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// tb_rf_wb_scheduler
//
// Directed-vector bench for rf_wb_scheduler with the default parameters
// (FIFO_DEPTH=2, STARVE_LIMIT=4). Inputs change on the falling edge and the
// combinational outputs are sampled 1ns later, well before the next rising
// edge; expected values are worked out by hand per vector.

module tb_rf_wb_scheduler;

    logic        clk;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wd;
    logic        md_issue;
    logic [4:0]  md_issue_rd;
    logic        md_valid;
    logic [4:0]  md_rd;
    logic [31:0] md_result;
    logic        md_ready;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        id_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wd;
    logic [1:0]  fifo_cnt;

    int vector_count;
    int miscompare_count;

    rf_wb_scheduler #(
        .FIFO_DEPTH   (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pipe_we     (pipe_we),
        .pipe_waddr  (pipe_waddr),
        .pipe_wd     (pipe_wd),
        .md_issue    (md_issue),
        .md_issue_rd (md_issue_rd),
        .md_valid    (md_valid),
        .md_rd       (md_rd),
        .md_result   (md_result),
        .md_ready    (md_ready),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .id_stall    (id_stall),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wd       (rf_wd),
        .fifo_cnt    (fifo_cnt)
    );

    // 10ns clock: rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Move to the next falling edge, drive one full input vector, then let
    // the combinational outputs settle.
    task automatic applyStimulus(
        input logic        r,
        input logic        pwe,
        input logic [4:0]  pwaddr,
        input logic [31:0] pwd,
        input logic        mvalid,
        input logic [4:0]  mrd,
        input logic [31:0] mresult,
        input logic        issue,
        input logic [4:0]  issue_rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [4:0]  rd
    );
        @(negedge clk);
        rst         = r;
        pipe_we     = pwe;
        pipe_waddr  = pwaddr;
        pipe_wd     = pwd;
        md_valid    = mvalid;
        md_rd       = mrd;
        md_result   = mresult;
        md_issue    = issue;
        md_issue_rd = issue_rd;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        #1;
    endtask

    // Single comparison point: counts every vector and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vector_count++;
        if (got !== exp) begin
            miscompare_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    initial begin
        vector_count     = 0;
        miscompare_count = 0;
        rst = 1'b1; pipe_we = 1'b0; pipe_waddr = 5'd0; pipe_wd = 32'd0;
        md_valid = 1'b0; md_rd = 5'd0; md_result = 32'd0;
        md_issue = 1'b0; md_issue_rd = 5'd0;
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;

        // Reset held two cycles with an M result and a pipe write pending
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1, 1, 5'd3, 32'h3333, 1, 5'd5, 32'h5555, 1, 5'd9, 5'd0, 5'd0, 5'd0);
            checkOutput("rst_rf_we", rf_we, 0);
            checkOutput("rst_md_ready", md_ready, 0);
            checkOutput("rst_fifo_cnt", fifo_cnt, 0);
            checkOutput("rst_id_stall", id_stall, 0);
        end
        applyStimulus(0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0);
        checkOutput("post_rst_fifo_cnt", fifo_cnt, 0);
        checkOutput("post_rst_md_ready", md_ready, 1);
        // Idle inputs, so crossing clock edges here changes no state
        for (int i = 0; i < 32; i++) begin
            id_rs1 = 5'(i); id_rs2 = 5'(i); id_rd = 5'(i);
            #1;
            checkOutput($sformatf("post_rst_busy_%0d", i), id_stall, 0);
        end

        // Bypass: mark x5 busy, then its result goes straight to the port
        applyStimulus(0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 5'd5, 5'd0, 5'd0, 5'd0);
        checkOutput("byp_issue_stall", id_stall, 0);
        applyStimulus(0, 0, 5'd0, 0, 1, 5'd5, 32'h12345678, 0, 5'd0, 5'd5, 5'd0, 5'd0);
        checkOutput("byp_busy_stall", id_stall, 1);
        checkOutput("byp_rf_we", rf_we, 1);
        checkOutput("byp_rf_waddr", rf_waddr, 5);
        checkOutput("byp_rf_wd", rf_wd, 32'h12345678);
        checkOutput("byp_md_ready", md_ready, 1);
        checkOutput("byp_fifo_cnt", fifo_cnt, 0);
        applyStimulus(0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 5'd5, 5'd0, 5'd0);
        checkOutput("byp_after_cnt", fifo_cnt, 0);
        checkOutput("byp_after_stall", id_stall, 0);
        checkOutput("byp_after_rf_we", rf_we, 0);

        // Conflict and ordering: x3 owns the port while r7, r8 queue up
        applyStimulus(0, 1, 5'd3, 32'h333, 1, 5'd7, 32'hA, 0, 5'd0, 5'd0, 5'd0, 5'd0);
        checkOutput("ord_a_waddr", rf_waddr, 3);
        checkOutput("ord_a_wd", rf_wd, 32'h333);
        checkOutput("ord_a_ready", md_ready, 1);
        checkOutput("ord_a_cnt", fifo_cnt, 0);
        applyStimulus(0, 1, 5'd3, 32'h334, 1, 5'd8, 32'hB, 0, 5'd0, 5'd0, 5'd0, 5'd0);
        checkOutput("ord_b_waddr", rf_waddr, 3);
        checkOutput("ord_b_cnt", fifo_cnt, 1);
        checkOutput("ord_b_ready", md_ready, 1);
        applyStimulus(0, 1, 5'd3, 32'h335, 1, 5'd9, 32'hC, 0, 5'd0, 5'd0, 5'd0, 5'd0);
        checkOutput("ord_c_we", rf_we, 1);
        checkOutput("ord_c_waddr", rf_waddr, 3);
        checkOutput("ord_c_cnt", fifo_cnt, 2);
        checkOutput("ord_c_ready_full", md_ready, 0);
        // Pipe drops: head r7 pops, r9 is held because the FIFO is still full
        applyStimulus(0, 0, 5'd0, 0, 1, 5'd9, 32'hC, 0, 5'd0, 5'd0, 5'd0, 5'd0);
        checkOutput("ord_d_waddr", rf_waddr, 7);
        checkOutput("ord_d_wd", rf_wd, 32'hA);
        checkOutput("ord_d_ready_full_pop", md_ready, 0);
        checkOutput("ord_d_cnt", fifo_cnt, 2);
        applyStimulus(0, 0, 5'd0, 0, 1, 5'd9, 32'hC, 0, 5'd0, 5'd0, 5'd0, 5'd0);
        checkOutput("ord_e_waddr", rf_waddr, 8);
        checkOutput("ord_e_wd", rf_wd, 32'hB);
        checkOutput("ord_e_ready", md_ready, 1);
        checkOutput("ord_e_cnt", fifo_cnt, 1);
        applyStimulus(0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0);
        checkOutput("ord_f_waddr", rf_waddr, 9);
        checkOutput("ord_f_wd", rf_wd, 32'hC);
        checkOutput("ord_f_cnt", fifo_cnt, 1);
        applyStimulus(0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0);
        checkOutput("ord_g_we", rf_we, 0);
        checkOutput("ord_g_cnt", fifo_cnt, 0);

        // RAW hazard on x10; an issue of x11 during the stall is ignored
        applyStimulus(0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 5'd10, 5'd0, 5'd0, 5'd0);
        checkOutput("raw_issue_stall", id_stall, 0);
        applyStimulus(0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 5'd11, 5'd10, 5'd0, 5'd0);
        checkOutput("raw_stall_1", id_stall, 1);
        applyStimulus(0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 5'd10, 5'd0, 5'd0);
        checkOutput("raw_stall_2", id_stall, 1);
        applyStimulus(0, 0, 5'd0, 0, 1, 5'd10, 32'h1010, 0, 5'd0, 5'd10, 5'd0, 5'd0);
        checkOutput("raw_write_stall", id_stall, 1);
        checkOutput("raw_write_waddr", rf_waddr, 10);
        applyStimulus(0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 5'd10, 5'd11, 5'd0);
        checkOutput("raw_released", id_stall, 0);

        // WAW hazard on x10 through id_rd
        applyStimulus(0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 5'd10, 5'd0, 5'd0, 5'd0);
        checkOutput("waw_issue_stall", id_stall, 0);
        applyStimulus(0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd10);
        checkOutput("waw_stall", id_stall, 1);
        applyStimulus(0, 0, 5'd0, 0, 1, 5'd10, 32'h2020, 0, 5'd0, 5'd0, 5'd0, 5'd10);
        checkOutput("waw_write_stall", id_stall, 1);
        applyStimulus(0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd10);
        checkOutput("waw_released", id_stall, 0);

        // Same-cycle set and clear of x12: the new issue keeps it busy
        applyStimulus(0, 0, 5'd0, 0, 1, 5'd12, 32'h1212, 1, 5'd12, 5'd0, 5'd0, 5'd0);
        checkOutput("setwin_rf_waddr", rf_waddr, 12);
        applyStimulus(0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 5'd0, 5'd12, 5'd0);
        checkOutput("setwin_stall", id_stall, 1);
        applyStimulus(0, 0, 5'd0, 0, 1, 5'd12, 32'h1313, 0, 5'd0, 5'd0, 5'd12, 5'd0);
        applyStimulus(0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 5'd0, 5'd12, 5'd0);
        checkOutput("setwin_cleared", id_stall, 0);

        // Starvation: one queued result held off by continuous pipe writes
        applyStimulus(0, 1, 5'd4, 32'h44, 1, 5'd6, 32'h66, 0, 5'd0, 5'd0, 5'd0, 5'd0);
        checkOutput("stv_push_waddr", rf_waddr, 4);
        for (int c = 1; c <= 4; c++) begin
            applyStimulus(0, 1, 5'd4, 32'h44, 0, 5'd0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0);
            checkOutput($sformatf("stv_cycle%0d_stall", c), id_stall, 0);
            checkOutput($sformatf("stv_cycle%0d_cnt", c), fifo_cnt, 1);
        end
        applyStimulus(0, 1, 5'd4, 32'h44, 0, 5'd0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0);
        checkOutput("stv_limit_stall", id_stall, 1);
        applyStimulus(0, 1, 5'd4, 32'h44, 0, 5'd0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0);
        checkOutput("stv_sat_stall", id_stall, 1);
        applyStimulus(0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0);
        checkOutput("stv_pop_stall", id_stall, 1);
        checkOutput("stv_pop_waddr", rf_waddr, 6);
        checkOutput("stv_pop_wd", rf_wd, 32'h66);
        applyStimulus(0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0);
        checkOutput("stv_done_stall", id_stall, 0);
        checkOutput("stv_done_cnt", fifo_cnt, 0);

        // x0 handling
        applyStimulus(0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 5'd0, 5'd0, 5'd0, 5'd0);
        applyStimulus(0, 0, 5'd0, 0, 1, 5'd0, 32'hDEAD, 0, 5'd0, 5'd0, 5'd0, 5'd0);
        checkOutput("x0_issue_no_busy", id_stall, 0);
        checkOutput("x0_md_ready", md_ready, 1);
        checkOutput("x0_rf_we", rf_we, 0);
        applyStimulus(0, 1, 5'd2, 32'h22, 1, 5'd13, 32'hD, 0, 5'd0, 5'd0, 5'd0, 5'd0);
        checkOutput("x0_discard_cnt", fifo_cnt, 0);
        applyStimulus(0, 1, 5'd2, 32'h22, 1, 5'd0, 32'hBEEF, 0, 5'd0, 5'd0, 5'd0, 5'd0);
        checkOutput("x0_busy_port_ready", md_ready, 1);
        checkOutput("x0_busy_port_cnt", fifo_cnt, 1);
        applyStimulus(0, 1, 5'd0, 32'hFFFF, 0, 5'd0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0);
        checkOutput("x0_pipe_cnt", fifo_cnt, 1);
        checkOutput("x0_pipe_drain_we", rf_we, 1);
        checkOutput("x0_pipe_drain_waddr", rf_waddr, 13);
        checkOutput("x0_pipe_drain_wd", rf_wd, 32'hD);
        applyStimulus(0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0);
        checkOutput("x0_drained_cnt", fifo_cnt, 0);

        // Reset mid-operation drops the queued result and busy x15
        applyStimulus(0, 1, 5'd3, 32'h3, 1, 5'd14, 32'hE, 1, 5'd15, 5'd0, 5'd0, 5'd0);
        applyStimulus(1, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 5'd15, 5'd0, 5'd0);
        checkOutput("mrst_rf_we", rf_we, 0);
        checkOutput("mrst_md_ready", md_ready, 0);
        checkOutput("mrst_id_stall", id_stall, 0);
        applyStimulus(0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 5'd15, 5'd0, 5'd0);
        checkOutput("mrst_cnt", fifo_cnt, 0);
        checkOutput("mrst_busy_cleared", id_stall, 0);
        checkOutput("mrst_no_drain", rf_we, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
        $finish;
    end

endmodule
